// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the bitcoin_hash result-scan path.
package bitcoin_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WR0,
    S_WR1,
    S_WR2,
    S_DONE
  } scan_state_t;

  localparam int          RESULT_WORDS  = 3;
  localparam logic [31:0] HASH_INIT_MAX = 32'hFFFFFFFF;

  typedef logic [15:0] word_addr_t;

endpackage

// File: rtl/scan_compare_unit.sv
// Registered first-win / running-minimum tracker over a stream of indexed hash words.
module scan_compare_unit
  import bitcoin_pkg::*;
#(
  parameter int NONCE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               valid,
  input  logic [31:0]        word,
  input  logic [NONCE_W-1:0] index,
  input  logic [31:0]        target,
  output logic               found,
  output logic [NONCE_W-1:0] win_nonce,
  output logic [31:0]        min_hash,
  output logic [NONCE_W-1:0] min_nonce
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      found     <= 1'b0;
      win_nonce <= '0;
      min_hash  <= HASH_INIT_MAX;
      min_nonce <= '0;
    end else if (clear) begin
      found     <= 1'b0;
      win_nonce <= '0;
      min_hash  <= HASH_INIT_MAX;
      min_nonce <= '0;
    end else if (valid) begin
      // strict compares: equality is not a win, ties keep the earlier index
      if (word < target && !found) begin
        found     <= 1'b1;
        win_nonce <= index;
      end
      if (word < min_hash) begin
        min_hash  <= word;
        min_nonce <= index;
      end
    end
  end

endmodule

// File: rtl/nonce_result_scan.sv
// Reads back NUM_NONCES hash words, tracks first win and minimum, then writes a 3-word record.
module nonce_result_scan
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int NONCE_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        hash_addr,
  input  logic [15:0]        result_addr,
  input  logic [31:0]        target,
  output logic               mem_clk,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [31:0]        mem_write_data,
  input  logic [31:0]        mem_read_data,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] win_nonce,
  output logic [31:0]        min_hash,
  output logic [NONCE_W-1:0] min_nonce
);

  localparam int CNT_W  = $clog2(NUM_NONCES + 1);
  localparam int STAGES = 1;

  scan_state_t        state, state_n;
  logic [CNT_W-1:0]   rc;
  logic [NONCE_W-1:0] cc;
  logic [STAGES:0]    vld_pipe;
  word_addr_t         hash_base, result_base;
  logic [31:0]        target_q;

  logic       clear, issue, rec_we, fin, cmp_vld;
  word_addr_t rec_addr;
  logic [31:0] rec_data;

  assign mem_clk = clk;
  // address registered at edge k returns data that is compared at edge k+2
  assign cmp_vld = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clear    = 1'b0;
    issue    = 1'b0;
    rec_we   = 1'b0;
    fin      = 1'b0;
    rec_addr = result_base;
    rec_data = '0;
    case (state)
      S_IDLE: if (start) begin
        clear   = 1'b1;
        issue   = 1'b1;
        state_n = (NUM_NONCES == 1) ? S_DRAIN : S_READ;
      end
      S_READ: begin
        issue = 1'b1;
        if (rc == CNT_W'(NUM_NONCES - 1)) state_n = S_DRAIN;
      end
      S_DRAIN: if (cmp_vld && cc == NONCE_W'(NUM_NONCES - 1)) state_n = S_WR0;
      S_WR0: begin
        rec_we   = 1'b1;
        rec_addr = result_base;
        rec_data = {found, 31'(win_nonce)};
        state_n  = S_WR1;
      end
      S_WR1: begin
        rec_we   = 1'b1;
        rec_addr = result_base + word_addr_t'(1);
        rec_data = min_hash;
        state_n  = S_WR2;
      end
      S_WR2: begin
        rec_we   = 1'b1;
        rec_addr = result_base + word_addr_t'(RESULT_WORDS - 1);
        rec_data = 32'(min_nonce);
        state_n  = S_DONE;
      end
      S_DONE: begin
        fin     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rc             <= '0;
      cc             <= '0;
      vld_pipe       <= '0;
      hash_base      <= '0;
      result_base    <= '0;
      target_q       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      mem_we   <= rec_we;
      if (cmp_vld) cc <= cc + 1'b1;
      if (clear) begin
        hash_base   <= hash_addr;
        result_base <= result_addr;
        target_q    <= target;
        mem_addr    <= hash_addr;
        rc          <= CNT_W'(1);
        cc          <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
      end else if (state == S_READ) begin
        mem_addr <= hash_base + word_addr_t'(rc);
        rc       <= rc + 1'b1;
      end
      if (rec_we) begin
        mem_addr       <= rec_addr;
        mem_write_data <= rec_data;
      end
      if (fin) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  scan_compare_unit #(.NONCE_W(NONCE_W)) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .valid     (cmp_vld),
    .word      (mem_read_data),
    .index     (cc),
    .target    (target_q),
    .found     (found),
    .win_nonce (win_nonce),
    .min_hash  (min_hash),
    .min_nonce (min_nonce)
  );

endmodule
